// File: rtl/decode_if.sv
// decode_if: decode-stage bundle carrying the fetch handshake, ID/EX outputs, EX result and WB write port
interface decode_if #(parameter int XLEN = 32);
  logic [31:0] instr;
  logic instr_valid, instr_ready, ex_ready;
  logic [XLEN-1:0] ex_a, ex_b, ex_result, wb_data;
  logic [2:0] ex_alu_ctrl;
  logic ex_execute, wb_we, illegal_op;
  logic [4:0] ex_rd, wb_rd;
  modport master(
    output instr, instr_valid, ex_ready, ex_result, wb_we, wb_rd, wb_data,
    input instr_ready, ex_a, ex_b, ex_alu_ctrl, ex_execute, ex_rd, illegal_op
  );
  modport slave(
    input instr, instr_valid, ex_ready, ex_result, wb_we, wb_rd, wb_data,
    output instr_ready, ex_a, ex_b, ex_alu_ctrl, ex_execute, ex_rd, illegal_op
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: opcode decode, register file with WB write-through bypass, ID/EX pipeline register.
// DECODE_FWD_EN adds EX-result forwarding and removes the EX hazard interlock.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32
) (
  input logic clk,
  input logic rst,
  decode_if.slave bus
);
  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic [XLEN-1:0] r_ex_a, r_ex_b;
  logic [2:0] r_ex_ctrl;
  logic r_ex_exec, r_illegal;
  logic [4:0] r_ex_rd;
  logic [2:0] w_op;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic w_illegal, w_exec, w_hazard, w_ready, w_accept, w_load, w_unused;
  logic [XLEN-1:0] w_a, w_b;
  assign w_op = bus.instr[31:29];
  assign w_rd = bus.instr[28:24];
  assign w_rs1 = bus.instr[23:19];
  assign w_rs2 = bus.instr[18:14];
  assign w_illegal = w_op > 3'd4;
  assign w_exec = w_op != 3'd0 && !w_illegal;
  always_comb begin
    w_a = (w_rs1 == 5'd0) ? '0 : (bus.wb_we && bus.wb_rd == w_rs1) ? bus.wb_data : r_regs[w_rs1];
    w_b = (w_rs2 == 5'd0) ? '0 : (bus.wb_we && bus.wb_rd == w_rs2) ? bus.wb_data : r_regs[w_rs2];
`ifdef DECODE_FWD_EN
    if (w_rs1 != 5'd0 && r_ex_exec && r_ex_rd == w_rs1) w_a = bus.ex_result;
    if (w_rs2 != 5'd0 && r_ex_exec && r_ex_rd == w_rs2) w_b = bus.ex_result;
    w_hazard = 1'b0;
`else
    w_hazard = bus.instr_valid && w_exec && r_ex_exec &&
               ((w_rs1 != 5'd0 && w_rs1 == r_ex_rd) || (w_rs2 != 5'd0 && w_rs2 == r_ex_rd));
`endif
  end
`ifdef DECODE_FWD_EN
  assign w_unused = ^bus.instr[13:0];
`else
  assign w_unused = ^{bus.instr[13:0], bus.ex_result};
`endif
  assign w_ready = bus.ex_ready && !w_hazard && !rst;
  assign w_accept = bus.instr_valid && w_ready;
  assign w_load = w_accept && w_exec;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end
  // ex_ready=0 freezes the whole ID/EX entry; the illegal pulse still clears every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_a <= '0;
      r_ex_b <= '0;
      r_ex_ctrl <= 3'd0;
      r_ex_exec <= 1'b0;
      r_ex_rd <= 5'd0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_illegal;
      if (bus.ex_ready) begin
        r_ex_a <= w_load ? w_a : '0;
        r_ex_b <= w_load ? w_b : '0;
        r_ex_ctrl <= w_load ? w_op : 3'd0;
        r_ex_exec <= w_load;
        r_ex_rd <= w_load ? w_rd : 5'd0;
      end
    end
  end
  assign bus.instr_ready = w_ready;
  assign bus.ex_a = r_ex_a;
  assign bus.ex_b = r_ex_b;
  assign bus.ex_alu_ctrl = r_ex_ctrl;
  assign bus.ex_execute = r_ex_exec;
  assign bus.ex_rd = r_ex_rd;
  assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (default build; DECODE_FWD_EN selects forwarding expectations)
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0] ctrl;
    logic exe;
    logic [4:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  exp_t last;
  decode_if #(.XLEN(32)) bus();
  decode_stage #(.XLEN(32), .NUM_REGS(32)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 14'h0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl, input logic exe, input logic [4:0] rd);
    sb.push_back(exp_t'{a, b, ctrl, exe, rd});
  endtask
  task automatic cmp_ex(input string tag, input exp_t e);
    chk({tag, "_a"}, bus.ex_a, e.a);
    chk({tag, "_b"}, bus.ex_b, e.b);
    chk({tag, "_ctrl"}, 32'(bus.ex_alu_ctrl), 32'(e.ctrl));
    chk({tag, "_exe"}, 32'(bus.ex_execute), 32'(e.exe));
    chk({tag, "_rd"}, 32'(bus.ex_rd), 32'(e.rd));
  endtask
  task automatic check_ex(input string tag);
    last = sb.pop_front();
    cmp_ex(tag, last);
  endtask
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctrl, input logic [4:0] rd);
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    push(a, b, ctrl, 1'b1, rd);
    tick();
    check_ex(tag);
    bus.instr_valid = 1'b0;
  endtask
  initial begin
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.ex_ready = 1'b1;
    bus.ex_result = '0;
    bus.wb_we = 1'b0;
    bus.wb_rd = '0;
    bus.wb_data = '0;
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("rst");
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_ill", 32'(bus.illegal_op), 0);
    rst = 1'b0;
    #1 chk("idle_ready", 32'(bus.instr_ready), 1);
    for (int i = 1; i < 32; i++) issue("rf_zero", mk(3'd3, 5'd0, 5'(i), 5'(i)), 0, 0, 3'd3, 5'd0);
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd5;
    bus.wb_data = 32'hDEAD_BEEF;
    issue("wb_byp", mk(3'd3, 5'd0, 5'd0, 5'd5), 0, 32'hDEAD_BEEF, 3'd3, 5'd0);
    bus.wb_rd = 5'd1;
    bus.wb_data = 32'hFFFF_1234;
    tick();
    bus.wb_rd = 5'd2;
    bus.wb_data = 32'h0000_0004;
    tick();
    bus.wb_we = 1'b0;
    issue("nor", mk(3'd4, 5'd3, 5'd1, 5'd2), 32'hFFFF_1234, 32'h4, 3'd4, 5'd3);
    issue("mul", mk(3'd1, 5'd4, 5'd1, 5'd2), 32'hFFFF_1234, 32'h4, 3'd1, 5'd4);
    bus.instr = mk(3'd3, 5'd6, 5'd4, 5'd1);
    bus.instr_valid = 1'b1;
    bus.ex_result = 32'h10;
`ifdef DECODE_FWD_EN
    #1 chk("fwd_ready", 32'(bus.instr_ready), 1);
    push(32'h10, 32'hFFFF_1234, 3'd3, 1'b1, 5'd6);
    tick();
    check_ex("fwd_xor");
`else
    #1 chk("haz_ready", 32'(bus.instr_ready), 0);
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("haz_bubble");
    bus.ex_result = 32'hBAD;
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd4;
    bus.wb_data = 32'h10;
    #1 chk("byp_ready", 32'(bus.instr_ready), 1);
    push(32'h10, 32'hFFFF_1234, 3'd3, 1'b1, 5'd6);
    tick();
    check_ex("byp_xor");
    bus.wb_we = 1'b0;
`endif
    bus.instr = mk(3'd2, 5'd7, 5'd2, 5'd2);
    bus.instr_valid = 1'b1;
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_ready", 32'(bus.instr_ready), 0);
      tick();
      cmp_ex("hold", last);
    end
    bus.ex_ready = 1'b1;
    #1 chk("rel_ready", 32'(bus.instr_ready), 1);
    issue("shift", mk(3'd2, 5'd7, 5'd2, 5'd2), 32'h4, 32'h4, 3'd2, 5'd7);
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("once");
    bus.instr = mk(3'd6, 5'd9, 5'd1, 5'd2);
    bus.instr_valid = 1'b1;
    #1 chk("ill_ready", 32'(bus.instr_ready), 1);
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("ill");
    chk("ill_pulse", 32'(bus.illegal_op), 1);
    bus.instr_valid = 1'b0;
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("ill_after");
    chk("ill_clear", 32'(bus.illegal_op), 0);
    issue("mul2", mk(3'd1, 5'd8, 5'd1, 5'd2), 32'hFFFF_1234, 32'h4, 3'd1, 5'd8);
    bus.ex_ready = 1'b0;
    rst = 1'b1;
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd1;
    bus.wb_data = 32'h5555_5555;
    push(0, 0, 0, 0, 0);
    tick();
    check_ex("rst2");
    chk("rst2_ill", 32'(bus.illegal_op), 0);
    chk("rst2_ready", 32'(bus.instr_ready), 0);
    rst = 1'b0;
    bus.wb_we = 1'b0;
    bus.ex_ready = 1'b1;
    issue("r1_cleared", mk(3'd3, 5'd0, 5'd1, 5'd1), 0, 0, 3'd3, 5'd0);
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd0;
    bus.wb_data = 32'h1234;
    tick();
    issue("r0_byp", mk(3'd3, 5'd0, 5'd0, 5'd0), 0, 0, 3'd3, 5'd0);
    bus.wb_we = 1'b0;
    issue("r0_read", mk(3'd3, 5'd0, 5'd0, 5'd0), 0, 0, 3'd3, 5'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
